// File: rtl/mac_accum_ctrl.sv
// Handshaked dot-product controller wrapped around an external combinational mac_unit.
// Stages one (weight, activation) beat per cycle and folds partial_sum_out back into its accumulator.
module mac_accum_ctrl #(
    parameter int BIT_WIDTH  = 8,
    parameter int ACCUM_BITS = 24,
    parameter int CNT_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_WIDTH-1:0]  in_weight,
    input  logic [BIT_WIDTH-1:0]  in_act,
    input  logic                  in_last,
    output logic [BIT_WIDTH-1:0]  mac_weight,
    output logic [BIT_WIDTH-1:0]  mac_inp,
    output logic [ACCUM_BITS-1:0] mac_psum_in,
    input  logic [ACCUM_BITS-1:0] mac_psum_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCUM_BITS-1:0] out_sum,
    output logic [CNT_BITS-1:0]   out_count,
    output logic                  out_ovf,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [1:0]            r_state;
    logic                  r_op_valid;
    logic                  r_op_last;
    logic [BIT_WIDTH-1:0]  r_weight;
    logic [BIT_WIDTH-1:0]  r_inp;
    logic [ACCUM_BITS-1:0] r_acc;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_ovf_sticky;
    logic                  r_out_valid;
    logic [ACCUM_BITS-1:0] r_out_sum;
    logic [CNT_BITS-1:0]   r_out_count;
    logic                  r_out_ovf;

    logic w_in_ready;
    logic w_accept;
    logic w_finish;
    logic w_wrap;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready; a result
    // transfers where out_valid && out_ready. Neither valid waits on its ready.
    assign w_in_ready = (r_state != S_DONE) && !(r_op_valid && r_op_last) && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_finish   = r_op_valid && r_op_last;
    // Product fits in the accumulator, so a wrap always leaves the new sum below the old one.
    assign w_wrap     = r_op_valid && (mac_psum_out < r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op_valid   <= 1'b0;
            r_op_last    <= 1'b0;
            r_weight     <= '0;
            r_inp        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sum    <= '0;
            r_out_count  <= '0;
            r_out_ovf    <= 1'b0;
        end else if (flush) begin
            // Result fields stay stale; only the valid qualifier drops.
            r_state      <= S_IDLE;
            r_op_valid   <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_op_valid <= w_accept;
            if (w_accept) begin
                r_weight  <= in_weight;
                r_inp     <= in_act;
                r_op_last <= in_last;
            end

            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_finish) begin
                r_out_sum    <= mac_psum_out;
                r_out_count  <= r_cnt + CNT_ONE;
                r_out_ovf    <= r_ovf_sticky || w_wrap;
                r_out_valid  <= 1'b1;
                r_acc        <= '0;
                r_cnt        <= '0;
                r_ovf_sticky <= 1'b0;
            end else if (r_op_valid) begin
                r_acc        <= mac_psum_out;
                r_cnt        <= r_cnt + CNT_ONE;
                r_ovf_sticky <= r_ovf_sticky || w_wrap;
            end

            case (r_state)
                S_IDLE:  if (w_accept) r_state <= S_RUN;
                S_RUN:   if (w_finish) r_state <= S_DONE;
                S_DONE:  if (r_out_valid && out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign mac_weight  = r_weight;
    assign mac_inp     = r_inp;
    assign mac_psum_in = r_acc;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_count   = r_out_count;
    assign out_ovf     = r_out_ovf;
    assign dbg_state   = r_state;

endmodule

// File: doc/mac_accum_ctrl.md
# mac_accum_ctrl

Sequential accumulation controller that sits on the other side of the `mac_unit` partial-sum interface. It accepts a stream of (weight, activation) beats over a valid/ready handshake and drives `weight`/`inp`/`partial_sum_in` into a combinational `mac_unit`. It captures `partial_sum_out` back into its accumulator each cycle and emits one accumulated dot-product per vector, the vector being terminated by `in_last`. It turns the free-running combinational MAC into a handshaked, cycle-accurate dot-product engine.

## Interface
- BIT_WIDTH, 8, operand width; must equal the `mac_unit` operand width.
- ACCUM_BITS, 24, accumulator width; must equal the `mac_unit` accumulator width; ACCUM_BITS >= 2*BIT_WIDTH is required.
- CNT_BITS, 8, width of the per-vector beat counter.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**.
- flush  in  1  synchronous abort of the current vector and any pending result.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  controller can accept a beat.
- in_weight  in  BIT_WIDTH  unsigned weight.
- in_act  in  BIT_WIDTH  unsigned activation.
- in_last  in  1  beat is the final element of the vector.
- mac_weight  out  BIT_WIDTH  registered operand to `mac_unit.weight`.
- mac_inp  out  BIT_WIDTH  registered operand to `mac_unit.inp`.
- mac_psum_in  out  ACCUM_BITS  accumulator to `mac_unit.partial_sum_in`.
- mac_psum_out  in  ACCUM_BITS  from `mac_unit.partial_sum_out`; equals weight*inp + psum_in mod 2^ACCUM_BITS.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACCUM_BITS  accumulated dot product.
- out_count  out  CNT_BITS  beats in the vector, mod 2^CNT_BITS.
- out_ovf  out  1  at least one accumulation in the vector wrapped.

## Operation
- State machine:
  - States: IDLE (accumulator 0, no operands staged), RUN (vector in progress), DONE (result held).
  - IDLE -> RUN on the first accepted beat.
  - RUN -> DONE on the edge at which the staged beat carries last.
  - DONE -> IDLE on `out_valid && out_ready`.
  - Any state -> IDLE on `flush`.
- Operand stage:
  - An accepted beat loads `mac_weight`, `mac_inp`, `op_last`, and sets `op_valid`.
  - A cycle with no accept clears `op_valid`; `mac_weight`/`mac_inp` keep their values.
- Accumulate:
  - On each edge with `op_valid=1`, `acc <= mac_psum_out` and `cnt <= cnt+1`.
  - `mac_psum_in` is driven directly from `acc`.
  - Overflow is sticky per vector: set when `mac_psum_out < acc` (unsigned) while `op_valid=1`. This test is exact because the product fits in ACCUM_BITS.
- Completion, on the edge with `op_valid && op_last`:
  - `out_sum <= mac_psum_out`, `out_count <= cnt+1`, `out_ovf <= sticky flag or this step's wrap`, `out_valid <= 1`.
  - `acc`, `cnt` and the sticky flag clear to 0.
- `in_ready = (state != DONE) && !(op_valid && op_last) && !flush`.
- Arithmetic is unsigned with modulo-2^ACCUM_BITS wrap; there is no saturation.
- `flush` has priority over every handshake in the same cycle:
  - clears `op_valid`, `acc`, `cnt`, the sticky flag and `out_valid`;
  - state returns to IDLE;
  - `out_sum`/`out_count`/`out_ovf` keep their stale values.
- Reset values: state IDLE; `mac_weight`, `mac_inp`, `mac_psum_in`, `out_sum`, `out_count`, `out_ovf`, `out_valid` all 0; `op_valid` 0; `in_ready` 1 (combinational from state).

## Timing
- Beat accepted in cycle C (`in_valid && in_ready` high): the operands are on `mac_*` during C+1, and `acc` reflects the beat from C+2.
- Throughput: one beat per cycle within a vector.
- After a last beat in cycle C:
  - `in_ready` is 0 in C+1.
  - `out_valid` is 1 from C+2 and held, with `out_sum`/`out_count`/`out_ovf` stable, until the `out_ready` cycle.
  - `in_ready` returns to 1 in the cycle after the result handshake (state IDLE).
- Bubbles are allowed: `in_valid` low mid-vector leaves `acc` unchanged.
- `out_valid` never depends combinationally on `out_ready`.
- `in_ready` depends combinationally only on state, `op_valid`/`op_last` and `flush`.
- Asserting `rst_n` low mid-vector clears all state immediately; no result is emitted.

## Test plan
- Single-beat vector:
  - Stimulus: w=3, x=5, last=1; `out_ready` held 1.
  - Required: out_valid two cycles after the accept; out_sum=15, out_count=1, out_ovf=0.
- Back-to-back 4-beat vector:
  - Stimulus: (1,2), (3,4), (5,6), (7,8) on consecutive cycles, last on the 4th.
  - Required: out_sum=100, out_count=4; in_ready low for exactly the cycle after the last accept until the result handshake.
- Backpressure:
  - Stimulus: vector (255,255)x2; out_ready held 0 for 5 cycles.
  - Required: out_valid held with out_sum=130050 stable; in_ready=0 throughout; the next vector is accepted only after out_ready=1.
- Overflow with ACCUM_BITS=16, BIT_WIDTH=8:
  - Stimulus: beats (255,255), (255,255).
  - Required: out_sum=(130050 mod 65536)=64514, out_ovf=1; a following vector (1,1) gives out_ovf=0.
- Bubbles plus flush:
  - Stimulus: (2,2), idle 3 cycles, (2,2), then flush together with in_valid.
  - Required: that beat is not accepted; acc returns to 0; the next vector (4,4) last gives out_sum=16, out_count=1.
- Reset mid-vector:
  - Stimulus: drop rst_n after 2 accepted beats.
  - Required: all outputs 0 and in_ready=1 during reset; the first result after release reflects only post-reset beats.
